// File: rtl/mac_engine_if.sv
// Valid/ready stream bundle for the MAC engine: A, B, C in and D out.
interface mac_engine_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  a_valid_i;
  logic [DATA_WIDTH-1:0] a_data_i;
  logic                  a_ready_o;
  logic                  b_valid_i;
  logic [DATA_WIDTH-1:0] b_data_i;
  logic                  b_ready_o;
  logic                  c_valid_i;
  logic [DATA_WIDTH-1:0] c_data_i;
  logic                  c_ready_o;
  logic                  d_valid_o;
  logic [DATA_WIDTH-1:0] d_data_o;
  logic                  d_ready_i;

  modport master (
    output a_valid_i, a_data_i, input a_ready_o,
    output b_valid_i, b_data_i, input b_ready_o,
    output c_valid_i, c_data_i, input c_ready_o,
    input  d_valid_o, d_data_o, output d_ready_i
  );

  modport slave (
    input  a_valid_i, a_data_i, output a_ready_o,
    input  b_valid_i, b_data_i, output b_ready_o,
    input  c_valid_i, c_data_i, output c_ready_o,
    output d_valid_o, d_data_o, input d_ready_i
  );
endinterface

// File: rtl/mac_engine.sv
// Two-stage signed multiply-accumulate engine with A/B/C input streams
// and a registered D result stream.
package mac_package;
  localparam int MAC_CNT_LEN = 1024;
  localparam int MAC_CW = $clog2(MAC_CNT_LEN) + 1;

  typedef struct packed {
    logic              clear;
    logic              enable;
    logic              simple_mul;
    logic              start;
    logic [4:0]        shift;
    logic [MAC_CW-1:0] len;
  } ctrl_engine_t;

  typedef struct packed {
    logic [MAC_CW-1:0] cnt;
  } flags_engine_t;
endpackage

module mac_engine
  import mac_package::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_LEN = MAC_CNT_LEN
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  ctrl_engine_t  ctrl_i,
  output flags_engine_t flags_o,
  mac_engine_if.slave   s
);

  localparam int CW = $clog2(CNT_LEN) + 1;
  localparam int PW = 2 * DATA_WIDTH;

  logic                  cfg_simple;
  logic [4:0]            cfg_shift;
  logic [CW-1:0]         cfg_len;
  logic [CW-1:0]         len_eff;

  logic                  prod_valid;
  logic [PW-1:0]         prod_q;
  logic [PW-1:0]         acc_q;
  logic [CW-1:0]         cnt_q;
  logic                  d_valid_q;
  logic [DATA_WIDTH-1:0] d_data_q;

  logic signed [PW-1:0]  a_ext;
  logic signed [PW-1:0]  b_ext;
  logic signed [PW-1:0]  mul_full;
  logic signed [PW-1:0]  prod_sh;
  logic [PW-1:0]         acc_sum;
  logic [CW:0]           cnt_inc;
  logic [DATA_WIDTH-1:0] d_next;

  logic run;
  logic d_free;
  logic last;
  logic s2_fire;
  logic d_load;
  logic c_take;
  logic ab_take;

  assign len_eff = (cfg_len == '0) ? CW'(1) : cfg_len;
  assign cnt_inc = (CW+1)'(cnt_q) + (CW+1)'(1);
  assign last    = (cnt_inc == {1'b0, len_eff});

  // start/clear/reset cycles never move data
  assign run = ctrl_i.enable & ~ctrl_i.start
             & ~ctrl_i.clear & ~rst_i;

  assign d_free  = ~d_valid_q | s.d_ready_i;

  assign s2_fire = run & prod_valid & (cfg_simple ? d_free
                 : (~last | (s.c_valid_i & d_free)));
  assign d_load  = s2_fire & (cfg_simple | last);
  assign c_take  = s2_fire & ~cfg_simple & last;

  assign ab_take = run & s.a_valid_i & s.b_valid_i
                 & (~prod_valid | s2_fire);

  assign a_ext = {{DATA_WIDTH{s.a_data_i[DATA_WIDTH-1]}},
                  s.a_data_i};
  assign b_ext = {{DATA_WIDTH{s.b_data_i[DATA_WIDTH-1]}},
                  s.b_data_i};
  assign mul_full = a_ext * b_ext;
  assign prod_sh  = mul_full >>> cfg_shift;

  assign acc_sum = acc_q + prod_q;
  assign d_next  = cfg_simple ? prod_q[DATA_WIDTH-1:0]
                 : acc_sum[DATA_WIDTH-1:0] + s.c_data_i;

  assign s.a_ready_o = ab_take;
  assign s.b_ready_o = ab_take;
  assign s.c_ready_o = c_take;
  assign s.d_valid_o = d_valid_q;
  assign s.d_data_o  = d_data_q;
  assign flags_o.cnt = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i | ctrl_i.clear) begin
      cfg_simple <= 1'b0;
      cfg_shift  <= '0;
      cfg_len    <= '0;
      prod_valid <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      d_valid_q  <= 1'b0;
      d_data_q   <= '0;
    end else begin
      if (ctrl_i.start) begin
        cfg_simple <= ctrl_i.simple_mul;
        cfg_shift  <= ctrl_i.shift;
        cfg_len    <= ctrl_i.len;
        prod_valid <= 1'b0;
        acc_q      <= '0;
        cnt_q      <= '0;
      end else begin
        if (s2_fire & ~cfg_simple) begin
          if (last) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else begin
            acc_q <= acc_sum;
            cnt_q <= cnt_inc[CW-1:0];
          end
        end
        if (ab_take) begin
          prod_q     <= prod_sh;
          prod_valid <= 1'b1;
        end else if (s2_fire) begin
          prod_valid <= 1'b0;
        end
      end
      if (d_load) begin
        d_valid_q <= 1'b1;
        d_data_q  <= d_next;
      end else if (s.d_ready_i) begin
        d_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_engine.sv
// Randomized bench for mac_engine: transaction-level reference model
// plus directed scenarios pinned with hand-computed results.
module tb_mac_engine;
  import mac_package::*;

  localparam int DW = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  logic clk = 1'b0;
  logic rst;
  logic clear_r, start_r, simple_r, en_r;
  logic [4:0] shift_r;
  logic [MAC_CW-1:0] len_r;
  ctrl_engine_t ctrl;
  flags_engine_t flags;

  always #5 clk = ~clk;

  assign ctrl = '{clear: clear_r, enable: en_r,
                  simple_mul: simple_r, start: start_r,
                  shift: shift_r, len: len_r};

  mac_engine_if #(.DATA_WIDTH(DW)) bus ();

  mac_engine #(.DATA_WIDTH(DW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ctrl_i (ctrl),
    .flags_o(flags),
    .s      (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  pair_t       ab_src[$];
  logic [31:0] c_all[$];
  int          c_ptr = 0;
  logic [31:0] exp_q[$];
  logic [31:0] d_seen[$];
  int          c_ready_cnt = 0;

  int p_ab = 100;
  int p_c  = 100;
  int p_dr = 100;
  int p_en = 100;

  logic        m_simple = 1'b0;
  logic [4:0]  m_shift = '0;
  int          m_len = 1;
  logic [63:0] m_acc = '0;
  int          m_cnt = 0;
  int          m_cidx = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: each A/B pair yields one product; a vector of len
  // products plus the next C value yields one D word.
  task automatic model_ab(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb, p;
    pa = $signed(a);
    pb = $signed(b);
    p = (pa * pb) >>> m_shift;
    if (m_simple) begin
      exp_q.push_back(p[31:0]);
    end else begin
      m_acc = m_acc + p;
      m_cnt++;
      if (m_cnt == m_len) begin
        exp_q.push_back(m_acc[31:0] + c_all[m_cidx]);
        m_cidx++;
        m_acc = '0;
        m_cnt = 0;
      end
    end
  endtask

  // Stimulus driver: pops on observed handshakes, redrives after edge.
  initial begin
    bus.a_valid_i = 1'b0;
    bus.b_valid_i = 1'b0;
    bus.c_valid_i = 1'b0;
    bus.a_data_i  = '0;
    bus.b_data_i  = '0;
    bus.c_data_i  = '0;
    bus.d_ready_i = 1'b0;
    en_r = 1'b1;
    forever begin
      @(posedge clk);
      if (bus.a_valid_i && bus.a_ready_o) void'(ab_src.pop_front());
      if (bus.c_valid_i && bus.c_ready_o) c_ptr++;
      #1;
      if (ab_src.size() > 0) begin
        bus.a_valid_i = $urandom_range(99) < p_ab;
        if (bus.a_valid_i)
          bus.b_valid_i = $urandom_range(99) < 95;
        else
          bus.b_valid_i = $urandom_range(99) < 10;
        bus.a_data_i = ab_src[0].a;
        bus.b_data_i = ab_src[0].b;
      end else begin
        bus.a_valid_i = 1'b0;
        bus.b_valid_i = 1'b0;
      end
      if (c_ptr < c_all.size()) begin
        bus.c_valid_i = $urandom_range(99) < p_c;
        bus.c_data_i = c_all[c_ptr];
      end else begin
        bus.c_valid_i = 1'b0;
      end
      bus.d_ready_i = $urandom_range(99) < p_dr;
      en_r = $urandom_range(99) < p_en;
    end
  end

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    if (bus.c_ready_o) c_ready_cnt++;
    if (rst || clear_r) begin
      exp_q.delete();
      m_acc = '0;
      m_cnt = 0;
      m_cidx = c_ptr;
      m_simple = 1'b0;
      m_shift = '0;
      m_len = 1;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("d_hold_valid", 64'(bus.d_valid_o), 64'd1);
        chk("d_hold_data", 64'(bus.d_data_o), 64'(hold_d));
      end
      if (bus.a_ready_o || bus.b_ready_o) begin
        chk("ab_ready_join", 64'(bus.a_ready_o), 64'(bus.b_ready_o));
        chk("ab_ready_needs_both",
            64'({bus.a_valid_i, bus.b_valid_i}), 64'd3);
      end
      if (bus.d_valid_o && bus.d_ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL d_extra: got %0h expected no output",
                   bus.d_data_o);
        end else begin
          chk("d_data", 64'(bus.d_data_o), 64'(exp_q.pop_front()));
        end
        d_seen.push_back(bus.d_data_o);
      end
      hold_v = bus.d_valid_o && !bus.d_ready_i;
      hold_d = bus.d_data_o;
      if (start_r) begin
        m_simple = simple_r;
        m_shift = shift_r;
        m_len = (len_r == 0) ? 1 : int'(len_r);
        m_acc = '0;
        m_cnt = 0;
      end else if (bus.a_valid_i && bus.a_ready_o) begin
        model_ab(bus.a_data_i, bus.b_data_i);
      end
    end
  end

  task automatic push_ab(input logic [31:0] a, input logic [31:0] b);
    pair_t p;
    p.a = a;
    p.b = b;
    ab_src.push_back(p);
  endtask

  task automatic configure(input logic s, input logic [4:0] sh,
                           input logic [MAC_CW-1:0] ln);
    @(posedge clk);
    #1;
    simple_r = s;
    shift_r = sh;
    len_r = ln;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((ab_src.size() > 0 || exp_q.size() > 0) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got %0d pending expected 0",
               ab_src.size() + exp_q.size());
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1;
    clear_r = 1'b1;
    @(posedge clk);
    #1;
    clear_r = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] v;
    case ($urandom_range(3))
      0: v = $urandom;
      1: v = 32'($signed($urandom_range(31)) - 16);
      2: begin
        case ($urandom_range(3))
          0: v = 32'h8000_0000;
          1: v = 32'h7fff_ffff;
          2: v = 32'h0;
          default: v = 32'hffff_ffff;
        endcase
      end
      default: v = $urandom_range(65535);
    endcase
    return v;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_ab, t_d, base, cr0, last_cnt, total;
    int seq[$];
    rst = 1'b1;
    clear_r = 1'b0;
    start_r = 1'b0;
    simple_r = 1'b0;
    shift_r = '0;
    len_r = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_d_valid", 64'(bus.d_valid_o), 64'd0);
    chk("rst_d_data", 64'(bus.d_data_o), 64'd0);
    chk("rst_a_ready", 64'(bus.a_ready_o), 64'd0);
    chk("rst_c_ready", 64'(bus.c_ready_o), 64'd0);
    chk("rst_cnt", 64'(flags.cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // simple multiply with latency
    configure(1'b1, 5'd0, '0);
    base = d_seen.size();
    cr0 = c_ready_cnt;
    push_ab(32'd3, 32'd5);
    push_ab(-32'sd4, 32'd6);
    t_ab = -1;
    t_d = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (t_ab < 0 && bus.a_valid_i && bus.a_ready_o) t_ab = i;
      if (t_d < 0 && bus.d_valid_o) t_d = i;
    end
    wait_idle();
    chk("mul_latency", 64'(t_d - t_ab), 64'd2);
    chk("mul_count", 64'(d_seen.size() - base), 64'd2);
    chk("mul_d0", 64'(d_seen[base]), 64'd15);
    chk("mul_d1", 64'(d_seen[base+1]), 64'hffff_ffe8);
    chk("mul_c_untouched", 64'(c_ready_cnt - cr0), 64'd0);

    // accumulate len=4 with C=100
    configure(1'b0, 5'd0, 11'd4);
    base = d_seen.size();
    cr0 = c_ready_cnt;
    c_all.push_back(32'd100);
    for (int i = 1; i <= 4; i++) push_ab(32'(i), 32'd1);
    last_cnt = -1;
    seq.delete();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (int'(flags.cnt) != last_cnt) begin
        last_cnt = int'(flags.cnt);
        seq.push_back(last_cnt);
      end
    end
    wait_idle();
    chk("acc_count", 64'(d_seen.size() - base), 64'd1);
    chk("acc_d", 64'(d_seen[base]), 64'd110);
    chk("acc_c_pulses", 64'(c_ready_cnt - cr0), 64'd1);
    chk("acc_seq_len", 64'(seq.size()), 64'd5);
    for (int i = 0; i < seq.size() && i < 5; i++)
      chk("acc_cnt_seq", 64'(seq[i]), 64'(i % 4));

    // arithmetic shift keeps sign
    configure(1'b1, 5'd4, '0);
    base = d_seen.size();
    push_ab(-32'sd256, 32'd2);
    wait_idle();
    chk("shift_d", 64'(d_seen[base]), 64'hffff_ffe0);

    // len 0 acts as len 1
    configure(1'b0, 5'd0, 11'd0);
    base = d_seen.size();
    c_all.push_back(32'd1);
    c_all.push_back(32'd10);
    push_ab(32'd2, 32'd3);
    push_ab(-32'sd1, 32'd5);
    wait_idle();
    chk("len0_d0", 64'(d_seen[base]), 64'd7);
    chk("len0_d1", 64'(d_seen[base+1]), 64'd5);

    // clear discards a pending D word
    p_dr = 0;
    c_all.push_back(32'd0);
    push_ab(32'd7, 32'd7);
    t_d = 0;
    while (!bus.d_valid_o && t_d < 20) begin
      @(negedge clk);
      t_d++;
    end
    chk("pend_d_valid", 64'(bus.d_valid_o), 64'd1);
    pulse_clear();
    chk("clear_d_valid", 64'(bus.d_valid_o), 64'd0);
    p_dr = 100;

    // clear mid-vector
    configure(1'b0, 5'd0, 11'd4);
    push_ab(32'd1, 32'd1);
    push_ab(32'd1, 32'd1);
    repeat (8) @(negedge clk);
    chk("mid_cnt", 64'(flags.cnt), 64'd2);
    pulse_clear();
    chk("clear_cnt", 64'(flags.cnt), 64'd0);
    chk("clear_d_valid2", 64'(bus.d_valid_o), 64'd0);

    // enable low freezes the vector
    configure(1'b0, 5'd0, 11'd4);
    base = d_seen.size();
    c_all.push_back(32'd1000);
    push_ab(32'd1, 32'd2);
    push_ab(32'd3, 32'd4);
    repeat (8) @(negedge clk);
    p_en = 0;
    repeat (3) @(posedge clk);
    push_ab(32'd5, 32'd6);
    push_ab(32'd7, 32'd8);
    repeat (6) @(negedge clk);
    chk("en_cnt_frozen", 64'(flags.cnt), 64'd2);
    chk("en_a_ready", 64'(bus.a_ready_o), 64'd0);
    p_en = 100;
    wait_idle();
    chk("en_d", 64'(d_seen[base]), 64'd1100);

    // D back-pressure, len 2
    configure(1'b0, 5'd0, 11'd2);
    p_dr = 0;
    for (int i = 0; i < 4; i++) c_all.push_back(rand_data());
    for (int i = 0; i < 8; i++) push_ab(rand_data(), rand_data());
    repeat (12) @(negedge clk);
    chk("bp_a_ready", 64'(bus.a_ready_o), 64'd0);
    chk("bp_d_valid", 64'(bus.d_valid_o), 64'd1);
    p_dr = 100;
    wait_idle();

    // randomized phases
    total = 0;
    while (total < 10000) begin
      logic sim;
      logic [4:0] sh;
      int ln, eff, nv, np;
      sim = $urandom_range(3) == 0;
      sh = 5'($urandom_range(31));
      if ($urandom_range(7) == 0) ln = $urandom_range(1024, 1);
      else ln = $urandom_range(16, 1);
      if ($urandom_range(15) == 0) ln = 0;
      eff = (ln == 0) ? 1 : ln;
      configure(sim, sh, 11'(ln));
      p_ab = $urandom_range(100, 50);
      p_c = $urandom_range(100, 40);
      p_dr = $urandom_range(100, 30);
      p_en = $urandom_range(100, 80);
      if (sim) begin
        np = $urandom_range(200, 20);
      end else begin
        nv = (256 / eff > 0) ? 256 / eff : 1;
        np = nv * eff;
        for (int i = 0; i < nv; i++) c_all.push_back(rand_data());
      end
      for (int i = 0; i < np; i++) push_ab(rand_data(), rand_data());
      wait_idle();
      p_ab = 100;
      p_c = 100;
      p_dr = 100;
      p_en = 100;
      total += np;
    end

    chk("end_ab_drained", 64'(ab_src.size()), 64'd0);
    chk("end_c_consumed", 64'(c_ptr), 64'(m_cidx));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_engine.md
MAC_ENGINE -- requirements
Module: mac_engine

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of a/b/c/d stream data.
REQ-002 Parameter CNT_LEN, mac_package::MAC_CNT_LEN (1024), maximum vector length; CW = $clog2(CNT_LEN)+1 (11).
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 ctrl_i  in  mac_package::ctrl_engine_t  clear, enable, simple_mul, start, shift[4:0], len[CW-1:0].
REQ-006 flags_o  out  mac_package::flags_engine_t  cnt[CW-1:0]: products accumulated in the current vector.
REQ-007 a_valid_i / a_data_i / a_ready_o  in/in/out  1/DATA_WIDTH/1  stream A, signed operand.
REQ-008 b_valid_i / b_data_i / b_ready_o  in/in/out  1/DATA_WIDTH/1  stream B, signed operand.
REQ-009 c_valid_i / c_data_i / c_ready_o  in/in/out  1/DATA_WIDTH/1  stream C, signed addend, one per output in accumulate mode.
REQ-010 d_valid_o / d_data_o / d_ready_i  out/out/in  1/DATA_WIDTH/1  stream D, result toward the D sink.

Function
REQ-011 Handshake: a transfer occurs in a cycle where valid and ready are both 1; ready is never a function of the same stream's valid alone.
REQ-012 A and B are joined: a_ready_o = b_ready_o = enable & a_valid_i & b_valid_i & stage-1 free-or-draining; no single-sided A or B transfer.
REQ-013 Stage 1: on an A/B transfer, register prod = signed(a)*signed(b) (2*DATA_WIDTH bits), arithmetically shifted right by cfg_shift; set prod_valid.
REQ-014 start=1 latches simple_mul, shift, len into config registers, zeroes accumulator and cnt, drops stage-1 content; if start and an A/B transfer coincide, start wins and no transfer occurs (ready forced 0).
REQ-015 len=0 in config is treated as len=1.
REQ-016 Simple-mul mode: stage 2 consumes prod when D register is empty or being emptied; d_data = prod[DATA_WIDTH-1:0]; C not consumed; cnt stays 0.
REQ-017 Accumulate mode, non-last product (cnt+1 < len): acc += prod (2*DATA_WIDTH bits, wrap mod 2^64), cnt += 1, one cycle, independent of D.
REQ-018 Accumulate mode, last product (cnt+1 = len): consumed only when c_valid_i=1 and D register empty-or-emptying; same cycle c_ready_o=1, d_data = (acc+prod)[DATA_WIDTH-1:0] + c_data (wrap mod 2^32), acc and cnt return to 0.
REQ-019 c_ready_o is 1 only in the cycle of REQ-018; otherwise 0.
REQ-020 Latency: A/B transfer in cycle N -> d_valid_o=1 from cycle N+2 when D and C are not stalling; throughput one A/B pair per cycle.
REQ-021 D output register: once d_valid_o=1, d_valid_o and d_data_o hold stable until d_ready_i=1; load and drain in same cycle allowed (full throughput).
REQ-022 enable=0: all ready outputs 0, stage 2 does not consume, acc/cnt frozen; pending d_valid_o stays asserted and may still drain.
REQ-023 clear=1: same effect as reset on all state (stage 1, acc, cnt, D register, config); takes priority over start and enable.
REQ-024 flags_o.cnt = current cnt register, range 0..len-1 in accumulate mode.
REQ-025 Back-pressure: D stall propagates: stage 1 full and not consumed -> a/b ready 0; no data lost or duplicated.

Reset
REQ-026 rst_i=1 at a clock edge: d_valid_o=0, d_data_o=0, a/b/c ready 0, cnt=0, acc=0, prod_valid=0, config simple_mul=0, shift=0, len=0.
REQ-027 Reset mid-vector discards partial accumulation and any pending D without emitting it; outputs reach reset values the cycle after the asserting edge.

Verification
REQ-028 Simple mul: start simple_mul=1 shift=0; A={3,-4}, B={5,6} back-to-back, d_ready=1 -> D={15,-24}, first d_valid 2 cycles after first transfer, C untouched.
REQ-029 Accumulate: start len=4 shift=0; A={1,2,3,4}, B={1,1,1,1}, C=100 -> D=110 once, cnt 0,1,2,3,0, c_ready pulses once.
REQ-030 Shift/sign: simple_mul shift=4, A=-256, B=2 -> D=-32 (0xFFFFFFE0).
REQ-031 Back-pressure: len=2, d_ready=0 for 10 cycles with continuous A/B/C -> one D held stable, a/b ready drop, no loss; after release results match golden model in order.
REQ-032 Boundaries: len=0 behaves as len=1 (D = A*B+C per pair); enable=0 mid-vector freezes cnt; clear mid-vector -> cnt=0, d_valid_o=0 next cycle.
REQ-033 Random: 10k random A/B/C, random valid/ready/enable gaps, random len 1..1024 and shift 0..31 -> D equals reference model bit-exact.
